// File: rtl/arm_rf_pkg.sv
// Shared defaults and FSM state type for the scoreboarded register file.
package arm_rf_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 15;
  localparam int DEF_ADDR_W   = 4;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by issue, cleared by writeback, bulk clear on re-init.
module rf_scoreboard
  import arm_rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  // Set is tested first so a same-cycle issue and writeback leaves the bit set.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (set_en && set_addr == ADDR_W'(r)) begin
          busy[r] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_W'(r)) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-through bypass, issue scoreboard and
// an init sweep that loads each register with its own index.
module reg_file_sb
  import arm_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 3,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     init_start,
  output logic                     init_busy
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  rf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [NUM_REGS-1:0] busy;
  logic                idle;
  logic                sweep_last;
  logic                restart;
  logic                wb_write;

  assign idle       = (state_q == ST_IDLE);
  assign sweep_last = (int'(cnt_q) == NUM_REGS - 1);
  assign restart    = idle && init_start;
  assign wb_write   = idle && wb_en && (int'(wb_dest) < NUM_REGS);
  assign init_busy  = !idle;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_last) state_d = ST_IDLE;
      ST_IDLE: if (init_start) state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!idle) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (restart) begin
        cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs <= '{default: '0};
    end else if (!idle) begin
      regs[cnt_q] <= DATA_W'(cnt_q);
    end else if (wb_write) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // Issue/writeback only reach the scoreboard in IDLE; out-of-range
  // addresses match no bit and so fall away there.
  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .clear    (restart),
    .set_en   (idle && issue_en),
    .set_addr (issue_dest),
    .clr_en   (idle && wb_en),
    .clr_addr (wb_dest),
    .busy     (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              in_range;

    assign a        = rd_addr[k*ADDR_W +: ADDR_W];
    assign in_range = (int'(a) < NUM_REGS);
    assign rd_busy[k] = in_range && busy[a];
    assign rd_data[k*DATA_W +: DATA_W] =
      !in_range                       ? '0      :
      (idle && wb_en && wb_dest == a) ? wb_data :
                                        regs[a];
  end

endmodule
